seq_counter: RTL and testbench

Parametrised multi-mode sequence counter. It is the general replacement for the team's fixed 4-bit permuted-sequence counters. One register steps through binary-up, binary-down, Gray-coded or maximal-length LFSR sequences of configurable width. It supports synchronous load, a programmable wrap limit and a terminal-count pulse, and it feeds sequencers and pseudo-random pattern sources elsewhere in the design.

---
 rtl/seq_counter.sv | 99 +++++++++
 tb/tb_seq_counter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/seq_counter.sv
// Multi-mode sequence counter: binary up/down with wrap limit, Gray-coded, or
// Fibonacci LFSR, with synchronous load and a registered terminal-count pulse.
module seq_counter #(
  parameter int                 WIDTH       = 4,
  parameter logic [WIDTH-1:0]   RESET_VALUE = WIDTH'(8),
  parameter logic [WIDTH-1:0]   LFSR_TAPS   = WIDTH'(4'b1100)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] count_limit,
  output logic [WIDTH-1:0] count_out,
  output logic             tc
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_GRAY = 2'd2,
    MODE_LFSR = 2'd3
  } mode_t;

  logic [WIDTH-1:0] state_reg, state_next;
  logic [WIDTH-1:0] count_next;
  logic             tc_next;
  logic             write_en;
  logic             wrap;
  mode_t            mode_sel;

  assign mode_sel = mode_t'(mode);
  assign write_en = load | enable;

  always_comb begin
    state_next = state_reg;
    wrap       = 1'b0;
    if (load) begin
      state_next = load_value;
    end else if (enable) begin
      case (mode_sel)
        MODE_UP: begin
          if (state_reg >= count_limit) begin
            state_next = '0;
            wrap       = 1'b1;
          end else begin
            state_next = state_reg + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (state_reg == '0 || state_reg > count_limit) begin
            state_next = count_limit;
            wrap       = 1'b1;
          end else begin
            state_next = state_reg - WIDTH'(1);
          end
        end
        MODE_GRAY: begin
          state_next = state_reg + WIDTH'(1);
          wrap       = (state_reg == '1);
        end
        default: begin
          // All-zero is the LFSR lockup state; kick it to 1 without signalling a wrap.
          if (state_reg == '0) begin
            state_next = WIDTH'(1);
          end else begin
            state_next = {state_reg[WIDTH-2:0], ^(state_reg & LFSR_TAPS)};
            wrap       = (state_next == RESET_VALUE);
          end
        end
      endcase
    end
  end

  always_comb begin
    count_next = state_next;
    if (mode_sel == MODE_GRAY)
      count_next = state_next ^ (state_next >> 1);
    tc_next = enable & ~load & wrap;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= RESET_VALUE;
      count_out <= RESET_VALUE;
      tc        <= 1'b0;
    end else begin
      tc <= tc_next;
      // count_out only re-encodes when the state is written, so a mode change
      // during hold leaves the displayed value alone.
      if (write_en) begin
        state_reg <= state_next;
        count_out <= count_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_counter.sv
// Scoreboard bench for seq_counter (WIDTH=4, RESET_VALUE=8, taps 4'b1100).
module tb_seq_counter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = '0;
  logic [1:0] mode = 2'd3;
  logic [3:0] count_limit = '0;
  logic [3:0] count_out;
  logic       tc;

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0] sb_q[$];

  logic [3:0] lfsr_tbl [15] = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                                4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};
  logic [3:0] gray_tbl [16] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12,
                                4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8, 4'd0};

  seq_counter #(.WIDTH(4), .RESET_VALUE(4'd8), .LFSR_TAPS(4'b1100)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .load(load),
    .load_value(load_value), .mode(mode), .count_limit(count_limit),
    .count_out(count_out), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, queue the expected result,
  // then compare just after the rising edge.
  task automatic step(input string tag, input logic ld, input logic en, input logic [3:0] lv,
                      input logic [1:0] md, input logic [3:0] lim,
                      input logic [3:0] exp_cnt, input logic exp_tc);
    logic [4:0] e;
    @(negedge clk);
    load = ld; enable = en; load_value = lv; mode = md; count_limit = lim;
    sb_q.push_back({exp_cnt, exp_tc});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, " count"}, 32'(count_out), 32'(e[4:1]));
    check({tag, " tc"}, 32'(tc), 32'(e[0]));
  endtask

  initial begin
    logic [3:0] prev;
    #12;
    check("reset count", 32'(count_out), 32'd8);
    check("reset tc", 32'(tc), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // LFSR full period from the reset seed
    for (int i = 0; i < 15; i++)
      step($sformatf("lfsr[%0d]", i), 1'b0, 1'b1, 4'd0, 2'd3, 4'd0, lfsr_tbl[i], i == 14);
    step("lfsr load0", 1'b1, 1'b1, 4'd0, 2'd3, 4'd0, 4'd0, 1'b0);
    step("lfsr lockup", 1'b0, 1'b1, 4'd0, 2'd3, 4'd0, 4'd1, 1'b0);

    // Binary up with limit 9, then limit dropped below S
    step("up load", 1'b1, 1'b0, 4'd0, 2'd0, 4'd9, 4'd0, 1'b0);
    for (int i = 1; i <= 9; i++)
      step($sformatf("up[%0d]", i), 1'b0, 1'b1, 4'd0, 2'd0, 4'd9, 4'(i), 1'b0);
    step("up wrap", 1'b0, 1'b1, 4'd0, 2'd0, 4'd9, 4'd0, 1'b1);
    for (int i = 1; i <= 6; i++)
      step($sformatf("up2[%0d]", i), 1'b0, 1'b1, 4'd0, 2'd0, 4'd9, 4'(i), 1'b0);
    step("up lim drop", 1'b0, 1'b1, 4'd0, 2'd0, 4'd3, 4'd0, 1'b1);
    step("up after", 1'b0, 1'b1, 4'd0, 2'd0, 4'd3, 4'd1, 1'b0);
    step("up lim0 a", 1'b1, 1'b0, 4'd0, 2'd0, 4'd0, 4'd0, 1'b0);
    step("up lim0 b", 1'b0, 1'b1, 4'd0, 2'd0, 4'd0, 4'd0, 1'b1);
    step("up lim0 c", 1'b0, 1'b1, 4'd0, 2'd0, 4'd0, 4'd0, 1'b1);

    // Binary down with limit 5
    step("dn load", 1'b1, 1'b0, 4'd2, 2'd1, 4'd5, 4'd2, 1'b0);
    step("dn 1", 1'b0, 1'b1, 4'd0, 2'd1, 4'd5, 4'd1, 1'b0);
    step("dn 0", 1'b0, 1'b1, 4'd0, 2'd1, 4'd5, 4'd0, 1'b0);
    step("dn wrap", 1'b0, 1'b1, 4'd0, 2'd1, 4'd5, 4'd5, 1'b1);
    step("dn 4", 1'b0, 1'b1, 4'd0, 2'd1, 4'd5, 4'd4, 1'b0);
    step("dn load12", 1'b1, 1'b0, 4'd12, 2'd1, 4'd5, 4'd12, 1'b0);
    step("dn above lim", 1'b0, 1'b1, 4'd0, 2'd1, 4'd5, 4'd5, 1'b1);

    // Gray: full cycle, one bit change per step
    step("gray load", 1'b1, 1'b0, 4'd0, 2'd2, 4'd0, 4'd0, 1'b0);
    prev = count_out;
    for (int i = 0; i < 16; i++) begin
      step($sformatf("gray[%0d]", i), 1'b0, 1'b1, 4'd0, 2'd2, 4'd0, gray_tbl[i], i == 15);
      check($sformatf("gray[%0d] bits", i), 32'($countones(prev ^ count_out)), 32'd1);
      prev = count_out;
    end

    // Load beats enable on a step that would wrap; then hold
    step("prio load3", 1'b1, 1'b0, 4'd3, 2'd0, 4'd3, 4'd3, 1'b0);
    step("prio load", 1'b1, 1'b1, 4'd7, 2'd0, 4'd3, 4'd7, 1'b0);
    for (int i = 0; i < 3; i++)
      step($sformatf("hold[%0d]", i), 1'b0, 1'b0, 4'd0, 2'd0, 4'd3, 4'd7, 1'b0);

    // Async reset between edges
    step("rst load11", 1'b1, 1'b0, 4'd11, 2'd3, 4'd0, 4'd11, 1'b0);
    load = 1'b0; enable = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async count", 32'(count_out), 32'd8);
    check("async tc", 32'(tc), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step("resume 1", 1'b0, 1'b1, 4'd0, 2'd3, 4'd0, 4'd1, 1'b0);
    step("resume 2", 1'b0, 1'b1, 4'd0, 2'd3, 4'd0, 4'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
